ysyx_24100005_ifu: RTL
======================

YSYX_24100005_IFU -- requirements
Module: ysyx_24100005_ifu

Interface
REQ-001 Parameter ADDR_W, default 32, fetch address and PC width in bits.
REQ-002 Parameter INST_W, default 32, instruction width in bits.
REQ-003 Parameter RESET_PC, default 32'h8000_0000, PC value after reset.
REQ-004 Parameter PC_STEP, default 4, sequential PC increment.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 redirect_valid  in  1  branch/jump redirect request from execute.
REQ-008 redirect_pc  in  ADDR_W  redirect target, sampled when redirect_valid=1.
REQ-009 imem_req_valid  out  1  fetch request valid.
REQ-010 imem_req_ready  in  1  memory accepts request.
REQ-011 imem_req_addr  out  ADDR_W  fetch address (equals pc).
REQ-012 imem_resp_valid  in  1  response valid, one cycle pulse per accepted request.
REQ-013 imem_resp_data  in  INST_W  fetched instruction.
REQ-014 inst_valid  out  1  instruction available to decode.
REQ-015 inst_ready  in  1  decode accepts instruction.
REQ-016 inst  out  INST_W  held instruction.
REQ-017 inst_pc  out  ADDR_W  PC of held instruction.
REQ-018 pc  out  ADDR_W  current fetch PC register.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, OUT; one outstanding request maximum.
REQ-020 IDLE -> REQ unconditionally; no outputs asserted in IDLE.
REQ-021 REQ: imem_req_valid=1; handshake (valid&ready) -> WAIT.
REQ-022 WAIT: on imem_resp_valid, capture imem_resp_data into inst and pc into inst_pc, -> OUT.
REQ-023 OUT: inst_valid=1; on inst_ready: pc <= pc+PC_STEP, -> REQ.
REQ-024 inst and inst_pc stable while inst_valid=1 and inst_ready=0.
REQ-025 PC arithmetic modulo 2^ADDR_W; 0xFFFF_FFFC + 4 wraps to 0x0000_0000.
REQ-026 Redirect in IDLE or REQ without handshake: pc <= redirect_pc next cycle, state REQ; address change while unaccepted is permitted.
REQ-027 Redirect in REQ coincident with handshake: pc <= redirect_pc, -> WAIT with drop flag set.
REQ-028 Redirect in WAIT: pc <= redirect_pc, drop flag set; response arriving same cycle or later is discarded, -> REQ.
REQ-029 Drop flag set: response discarded, no OUT entry, flag cleared, -> REQ.
REQ-030 Redirect in OUT: pc <= redirect_pc, -> REQ; if inst_ready same cycle the transfer still completes (inst_valid was high), no PC_STEP applied.
REQ-031 imem_resp_valid outside WAIT ignored.
REQ-032 Redirect has priority over sequential increment in every state.

Reset
REQ-033 rst=1 at a clock edge: state <= IDLE, pc <= RESET_PC, drop flag <= 0, inst <= 0, inst_pc <= 0, regardless of state (mid-fetch responses discarded).
REQ-034 While rst=1: imem_req_valid=0, inst_valid=0; first request the second cycle after rst deasserts.

Structure
REQ-035 FSM state encodings and default RESET_PC live in the shared package/header ysyx_24100005_pkg.
REQ-036 PC register instantiates ysyx_24100005_Reg (WIDTH=ADDR_W, RESET_VAL=RESET_PC); FSM, drop flag, inst buffer are local.

Verification
REQ-037 Reset release, imem_req_ready=1, 1-cycle response latency, inst_ready=1 -> imem_req_addr sequence 0x8000_0000, 0x8000_0004, 0x8000_0008; inst_pc matches each.
REQ-038 inst_ready=0 for 5 cycles with inst=0x0000_0013 held -> inst/inst_pc unchanged, no new imem request, pc steps by 4 only after acceptance.
REQ-039 Redirect to 0x8000_0100 while in WAIT -> pending response discarded, inst_valid never asserts for old PC, next request addr 0x8000_0100.
REQ-040 Redirect to 0x8000_0200 same cycle as inst_ready in OUT -> instruction transferred once, next request addr 0x8000_0200 (not +4).
REQ-041 RESET_PC=32'hFFFF_FFFC, normal fetch -> second request addr 0x0000_0000.
REQ-042 rst asserted in WAIT, response arrives next cycle -> response ignored, pc=RESET_PC, restart from IDLE.

Source files
------------

// File: rtl/ysyx_24100005_pkg.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_pkg
// Shared definitions for the instruction fetch unit:
//   - ifu_state_e      : fetch FSM state encoding
//   - DEFAULT_RESET_PC : PC value loaded on reset unless overridden
//   - pc_advance()     : sequential PC step, wrapping modulo 2^32
// -----------------------------------------------------------------------------
package ysyx_24100005_pkg;

  // Fetch FSM states. The encoding is fixed so that waveforms read the same
  // across builds.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // post-reset idle cycle, nothing asserted
    S_REQ  = 2'd1,  // fetch request presented to instruction memory
    S_WAIT = 2'd2,  // request accepted, waiting for the response pulse
    S_OUT  = 2'd3   // instruction held for decode
  } ifu_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam int unsigned DEFAULT_PC_STEP  = 4;

  // Sequential PC advance. Plain unsigned addition truncated to the PC width,
  // so the top of the address space wraps around to zero.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc,
                                             input logic [31:0] step);
    return pc + step;
  endfunction

endpackage : ysyx_24100005_pkg

// File: rtl/ysyx_24100005_Reg.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_Reg
// Generic register with write enable and synchronous active-high reset.
//   clk       in   clock, rising edge
//   rst       in   synchronous reset, loads RESET_VAL
//   wen_i     in   write enable
//   d_i       in   WIDTH  next value, loaded when wen_i=1
//   q_o       out  WIDTH  registered value
// -----------------------------------------------------------------------------
module ysyx_24100005_Reg #(
  parameter int unsigned       WIDTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  // NOTE: sequential state is always assigned with <= so that every flop
  // samples the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= RESET_VAL;
    end else if (wen_i) begin
      q_o <= d_i;
    end
  end

endmodule : ysyx_24100005_Reg

// File: rtl/ysyx_24100005_ifu.sv
// -----------------------------------------------------------------------------
// ysyx_24100005_ifu
// Instruction fetch unit. Fetches one instruction at a time from instruction
// memory (at most one outstanding request), holds it for decode, and follows
// branch/jump redirects from execute.
//
// Ports:
//   clk              in   clock, all state updates on the rising edge
//   rst              in   synchronous active-high reset
//   redirect_valid   in   redirect request from execute
//   redirect_pc      in   ADDR_W  redirect target
//   imem_req_valid   out  fetch request valid
//   imem_req_ready   in   memory accepts the request
//   imem_req_addr    out  ADDR_W  fetch address (always the PC register)
//   imem_resp_valid  in   response pulse, one per accepted request
//   imem_resp_data   in   INST_W  fetched instruction
//   inst_valid       out  instruction available to decode
//   inst_ready       in   decode accepts the instruction
//   inst             out  INST_W  held instruction
//   inst_pc          out  ADDR_W  PC of the held instruction
//   pc               out  ADDR_W  current fetch PC
//
// Redirect behaviour:
//   - IDLE/REQ without handshake: PC replaced, request continues from REQ.
//   - REQ with handshake, or WAIT: the in-flight response is marked for
//     dropping; once it arrives it is discarded and fetch restarts in REQ.
//     A redirect in WAIT that coincides with the response discards it at once.
//   - OUT: PC replaced; a coincident inst_ready still completes the transfer
//     but the sequential step is suppressed.
// -----------------------------------------------------------------------------
module ysyx_24100005_ifu
  import ysyx_24100005_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INST_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned         PC_STEP  = DEFAULT_PC_STEP
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,

  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [INST_W-1:0] imem_resp_data,

  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,

  output logic [ADDR_W-1:0] pc
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  ifu_state_e        state_q;
  logic              drop_q;        // in-flight response belongs to a stale PC
  logic              req_valid_q;   // registered imem_req_valid
  logic              inst_valid_q;  // registered inst_valid
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              pc_we;

  logic              req_fire;
  logic              out_fire;

  assign req_fire = req_valid_q && imem_req_ready;
  assign out_fire = inst_valid_q && inst_ready;

  // ---------------------------------------------------------------------------
  // PC next-state: a redirect always wins over the sequential step, and the
  // step is only taken when decode accepts the held instruction.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    pc_we = 1'b0;
    pc_d  = ADDR_W'(pc_advance(32'(pc_q), 32'(PC_STEP)));
    if (redirect_valid) begin
      pc_we = 1'b1;
      pc_d  = redirect_pc;
    end else if (state_q == S_OUT && out_fire) begin
      pc_we = 1'b1;
    end
  end

  ysyx_24100005_Reg #(
    .WIDTH     (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst   (rst),
    .wen_i (pc_we),
    .d_i   (pc_d),
    .q_o   (pc_q)
  );

  // ---------------------------------------------------------------------------
  // Fetch FSM with registered request/valid outputs and the instruction buffer.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_q     <= S_REQ;
          req_valid_q <= 1'b1;
        end

        S_REQ: begin
          // Without a handshake the request stays up; a redirect only changes
          // the address through the PC register.
          if (req_fire) begin
            state_q     <= S_WAIT;
            req_valid_q <= 1'b0;
            drop_q      <= redirect_valid;
          end
        end

        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop_q || redirect_valid) begin
              // Stale response: discard and refetch from the new PC.
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              drop_q      <= 1'b0;
            end else begin
              state_q      <= S_OUT;
              inst_valid_q <= 1'b1;
              inst_q       <= imem_resp_data;
              inst_pc_q    <= pc_q;
            end
          end else if (redirect_valid) begin
            // The response is still owed by memory; wait for it, then drop it,
            // so there is never more than one request outstanding.
            drop_q <= 1'b1;
          end
        end

        S_OUT: begin
          if (redirect_valid || out_fire) begin
            state_q      <= S_REQ;
            inst_valid_q <= 1'b0;
            req_valid_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign pc             = pc_q;

endmodule : ysyx_24100005_ifu
